// File: rtl/cpu_pkg.sv
// Shared CPU types and encodings: bus widths, memory-op codes and
// load/store unit state.
package cpu_pkg;

  localparam int REG_BUS_W  = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    MEMOP_NOP   = 2'b00,
    MEMOP_LOAD  = 2'b01,
    MEMOP_STORE = 2'b10,
    MEMOP_RSVD  = 2'b11
  } memop_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_DONE
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a single data-memory
// transaction is outstanding, with a bounded wait and a sticky timeout flag.
module mem_lsu
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            memop_i,
  input  logic [REG_BUS_W-1:0]  addr_i,
  input  logic [REG_BUS_W-1:0]  sdata_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_BUS_W-1:0]  wdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_BUS_W-1:0]  wdata_o,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [REG_BUS_W-1:0]  dmem_addr_o,
  output logic [REG_BUS_W-1:0]  dmem_wdata_o,
  input  logic [REG_BUS_W-1:0]  dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic                  err_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t           state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [REG_BUS_W-1:0] addr_q, addr_d;
  logic [REG_BUS_W-1:0] wdata_q, wdata_d;
  logic [REG_BUS_W-1:0] load_q, load_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;
  logic                 mem_op;

  assign mem_op = (memop_i == MEMOP_LOAD) || (memop_i == MEMOP_STORE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    abort_d = abort_q;
    case (state_q)
      LSU_IDLE: begin
        if (mem_op) begin
          state_d = LSU_REQ;
          req_d   = 1'b1;
          we_d    = (memop_i == MEMOP_STORE);
          addr_d  = addr_i;
          wdata_d = sdata_i;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      LSU_REQ: begin
        // ack is tested first so a same-cycle timeout never raises err
        if (dmem_ack_i) begin
          load_d  = dmem_rdata_i;
          req_d   = 1'b0;
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    wd_o    = wd_i;
    wreg_o  = 1'b0;
    wdata_o = wdata_i;
    stall_o = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        stall_o = mem_op;
        wreg_o  = mem_op ? 1'b0 : wreg_i;
      end
      LSU_REQ: stall_o = 1'b1;
      LSU_DONE: begin
        if (!we_q && !abort_q) begin
          wreg_o  = wreg_i;
          wdata_o = load_q;
        end
      end
      default: stall_o = 1'b0;
    endcase
    // write-back path is combinational from the inputs, so gate it in reset
    if (!rst) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
      stall_o = 1'b0;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = req_q & we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, reset corner case,
// then random back-to-back operations against a transaction-level model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  memop_i;
  logic [15:0] addr_i, sdata_i, wdata_i;
  logic [3:0]  wd_i;
  logic        wreg_i;
  logic [3:0]  wd_o;
  logic        wreg_o;
  logic [15:0] wdata_o;
  logic        stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        dmem_ack_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .memop_i(memop_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i(dmem_ack_i), .err_o(err_o)
  );

  // d = REQ cycle (1-based) in which ack is given; 0 = never acked
  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [3:0]  wd;
    logic        wreg;
    logic [15:0] wdata;
    int          d;
    logic [15:0] rdata;
    int          exp_stall;
    logic        exp_wreg;
    logic [15:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: how long the pipeline stalls and what reaches write-back.
  function automatic vec_t model(input vec_t v, input logic err_in);
    vec_t r = v;
    bit mem   = (v.op == 2'b01) || (v.op == 2'b10);
    bit abort = mem && (v.d == 0 || v.d > 15);
    r.exp_err   = err_in | abort;
    r.exp_stall = mem ? 1 + (abort ? 15 : v.d) : 0;
    r.exp_wreg  = mem ? ((v.op == 2'b01 && !abort) ? v.wreg : 1'b0) : v.wreg;
    r.exp_wdata = mem ? v.rdata : v.wdata;
    return r;
  endfunction

  // Presents one op as the held EX/MEM stage; returns what appeared at write-back.
  task automatic run_op(input vec_t v, output int stall_cnt, output logic [3:0] dwd,
                        output logic dwreg, output logic [15:0] dwdata, output logic derr);
    bit done = 0;
    memop_i = v.op; addr_i = v.addr; sdata_i = v.sdata;
    wd_i = v.wd; wreg_i = v.wreg; wdata_i = v.wdata;
    stall_cnt = 0; dwd = '0; dwreg = 1'b0; dwdata = '0; derr = 1'b0;
    if (!(v.op == 2'b01 || v.op == 2'b10)) begin
      dmem_ack_i = 1'($urandom_range(0, 1)); dmem_rdata_i = 16'($urandom);
      #2;
      dwd = wd_o; dwreg = wreg_o; dwdata = wdata_o; derr = err_o;
      stall_cnt = int'(stall_o);
      chk("nop_req", dmem_req_o, 0);
      @(posedge clk); #1;
      return;
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem_ack_i = 1'b0; dmem_rdata_i = 16'($urandom);
      #1;
      if (!stall_o && cyc > 0) begin
        dwd = wd_o; dwreg = wreg_o; dwdata = wdata_o; derr = err_o;
        chk("done_req", dmem_req_o, 0);
        chk("done_we", dmem_we_o, 0);
        chk("done_addr_hold", dmem_addr_o, v.addr);
        dmem_ack_i = 1'($urandom_range(0, 1));
        done = 1;
      end else begin
        stall_cnt++;
        chk("stall_wreg", wreg_o, 0);
        if (cyc == 0) begin
          chk("idle_req", dmem_req_o, 0);
          dmem_ack_i = 1'($urandom_range(0, 1));
        end else begin
          chk("req", dmem_req_o, 1);
          chk("req_we", dmem_we_o, (v.op == 2'b10));
          chk("req_addr", dmem_addr_o, v.addr);
          chk("req_wdata", dmem_wdata_o, v.sdata);
          if (cyc == v.d) begin
            dmem_ack_i = 1'b1; dmem_rdata_i = v.rdata;
          end
        end
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL op_bound: got no DONE within 40 cycles expected DONE");
    end
    dmem_ack_i = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    int st; logic [3:0] dwd; logic dwreg; logic [15:0] dwdata; logic derr;
    run_op(v, st, dwd, dwreg, dwdata, derr);
    chk("stall_cycles", st, v.exp_stall);
    chk("wb_wd", dwd, v.wd);
    chk("wb_wreg", dwreg, v.exp_wreg);
    if (v.exp_wreg) chk("wb_wdata", dwdata, v.exp_wdata);
    chk("err", derr, v.exp_err);
  endtask

  vec_t tbl[8];
  logic err_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     addr     sdata    wd  wreg wdata    d   rdata    stall wreg wdata    err
    tbl[0] = '{2'b00, 16'h0000, 16'h0000, 3, 1, 16'h0042, 0, 16'h0000, 0,  1, 16'h0042, 0};
    tbl[1] = '{2'b01, 16'h0010, 16'h0000, 7, 1, 16'h5555, 3, 16'hBEEF, 4,  1, 16'hBEEF, 0};
    tbl[2] = '{2'b10, 16'h0020, 16'h1234, 2, 1, 16'h6666, 1, 16'h0000, 2,  0, 16'h0000, 0};
    tbl[3] = '{2'b01, 16'h0030, 16'h0000, 9, 1, 16'h7777, 15, 16'hCAFE, 16, 1, 16'hCAFE, 0};
    tbl[4] = '{2'b11, 16'h0040, 16'h0000, 4, 1, 16'h0777, 0, 16'h0000, 0,  1, 16'h0777, 0};
    tbl[5] = '{2'b01, 16'h0050, 16'h0000, 5, 1, 16'h1111, 0, 16'h0000, 16, 0, 16'h0000, 1};
    tbl[6] = '{2'b01, 16'h0060, 16'h0000, 8, 0, 16'h2222, 2, 16'h0F0F, 3,  0, 16'h0000, 1};
    tbl[7] = '{2'b10, 16'h0070, 16'hA5A5, 1, 1, 16'h3333, 0, 16'h0000, 16, 0, 16'h0000, 1};

    rst = 1'b0; memop_i = 2'b01; addr_i = 16'h1234; sdata_i = 16'h5678;
    wd_i = 4'd5; wreg_i = 1'b1; wdata_i = 16'h1111; dmem_rdata_i = '0; dmem_ack_i = 1'b0;
    #2;
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_we", dmem_we_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_mwdata", dmem_wdata_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk); #3;
    rst = 1'b1; memop_i = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) check_vec(tbl[i]);

    // reset in the middle of an outstanding load
    memop_i = 2'b01; addr_i = 16'h0ABC; sdata_i = 16'h0; wd_i = 4'd6; wreg_i = 1'b1;
    wdata_i = 16'h3333; dmem_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("midreq_req", dmem_req_o, 1);
    rst = 1'b0;
    #1;
    chk("midreq_rst_req", dmem_req_o, 0);
    chk("midreq_rst_stall", stall_o, 0);
    chk("midreq_rst_wd", wd_o, 0);
    chk("midreq_rst_wreg", wreg_o, 0);
    chk("midreq_rst_wdata", wdata_o, 0);
    chk("midreq_rst_addr", dmem_addr_o, 0);
    chk("midreq_rst_err", err_o, 0);
    @(posedge clk); #3;
    rst = 1'b1; memop_i = 2'b00;
    #1;
    chk("post_rst_idle_stall", stall_o, 0);
    chk("post_rst_idle_wd", wd_o, 6);
    chk("post_rst_idle_wreg", wreg_o, 1);
    @(posedge clk); #1;

    err_exp = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.op = 2'($urandom_range(0, 3));
      v.addr = 16'($urandom); v.sdata = 16'($urandom);
      v.wd = 4'($urandom); v.wreg = 1'($urandom); v.wdata = 16'($urandom);
      v.d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 17));
      v.rdata = 16'($urandom);
      v = model(v, err_exp);
      err_exp = v.exp_err;
      check_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TIMEOUT, default 15, is the maximum cycles to wait for dmem_ack_i before aborting.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst, input, 1: asynchronous active-low reset.
REQ-005 Port memop_i, input, 2: memory operation from EX/MEM; 00 NOP, 01 LOAD, 10 STORE, 11 reserved (treated as NOP).
REQ-006 Port addr_i, input, 16: data word address.
REQ-007 Port sdata_i, input, 16: store data.
REQ-008 Port wd_i, input, 4: destination register address.
REQ-009 Port wreg_i, input, 1: destination write enable.
REQ-010 Port wdata_i, input, 16: ALU result.
REQ-011 Port wd_o, output, 4: destination register address to MEM/WB.
REQ-012 Port wreg_o, output, 1: write enable to MEM/WB.
REQ-013 Port wdata_o, output, 16: write-back data to MEM/WB.
REQ-014 Port stall_o, output, 1: holds PC, IF/ID, ID/EX and EX/MEM.
REQ-015 Port dmem_req_o, output, 1: data memory request.
REQ-016 Port dmem_we_o, output, 1: 1 = write, 0 = read.
REQ-017 Port dmem_addr_o, output, 16: memory address.
REQ-018 Port dmem_wdata_o, output, 16: memory write data.
REQ-019 Port dmem_rdata_i, input, 16: memory read data, valid when dmem_ack_i = 1.
REQ-020 Port dmem_ack_i, input, 1: single-cycle completion strobe.
REQ-021 Port err_o, output, 1: sticky bus-timeout flag.

Function
REQ-022 FSM SHALL have three states: IDLE, REQ and DONE.
REQ-023 IDLE with NOP: outputs wd_o, wreg_o and wdata_o SHALL pass wd_i, wreg_i and wdata_i through combinationally; stall_o = 0.
REQ-024 IDLE with LOAD/STORE: stall_o = 1 combinationally and wreg_o = 0; next edge goes to REQ, latching addr_i, sdata_i and the write flag.
REQ-025 REQ: dmem_req_o = 1 (registered), dmem_we_o, dmem_addr_o and dmem_wdata_o held stable; stall_o = 1; wreg_o = 0.
REQ-026 REQ with dmem_ack_i = 1: capture dmem_rdata_i into the load register, clear req, next state DONE; load-to-ack minimum latency is 2 cycles.
REQ-027 REQ timeout: a counter increments each REQ cycle; reaching TIMEOUT without ack drops req, sets err_o and goes to DONE with abort flag.
REQ-028 Ack and timeout in the same cycle: ack wins and err_o is not set.
REQ-029 DONE: stall_o = 0 and wd_o = wd_i; LOAD gives wreg_o = wreg_i and wdata_o = load register; STORE or abort gives wreg_o = 0; next state IDLE unconditionally.
REQ-030 dmem_ack_i outside REQ SHALL be ignored.
REQ-031 err_o SHALL remain set until reset.
REQ-032 Back-to-back memory ops: an op presented in the IDLE cycle after DONE SHALL start a new transaction; no op is lost or repeated.
REQ-033 Outside REQ: dmem_req_o = 0, dmem_we_o = 0, and address/data hold their last value.

Reset
REQ-034 While rst = 0: state IDLE, dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_wdata_o = 0, load register = 0, counter = 0, err_o = 0.
REQ-035 While rst = 0, outputs wd_o = 0, wreg_o = 0, wdata_o = 0 and stall_o = 0.
REQ-036 Reset during REQ SHALL drop dmem_req_o immediately, without waiting for a clock edge.

Structure
REQ-037 Shared package cpu_pkg SHALL hold: RegBus width (16), RegAddrBus width (4), the memop encodings, and lsu_state_t.
REQ-038 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-039 NOP, wd_i = 3, wreg_i = 1, wdata_i = 0x0042 -> same cycle: wd_o = 3, wreg_o = 1, wdata_o = 0x0042, stall_o = 0.
REQ-040 LOAD addr 0x0010, ack after 3 REQ cycles, rdata 0xBEEF -> stall_o high 4 cycles; DONE cycle: wreg_o = 1, wdata_o = 0xBEEF.
REQ-041 STORE addr 0x0020, data 0x1234, ack on first REQ cycle -> dmem_we_o = 1, addr = 0x0020, wdata = 0x1234; DONE cycle: wreg_o = 0.
REQ-042 LOAD with no ack -> after 15 REQ cycles: req drops, err_o = 1, DONE with wreg_o = 0; err_o stays 1 until rst.
REQ-043 Ack in the 15th REQ cycle -> load completes and err_o = 0.
REQ-044 rst pulsed low mid-REQ -> dmem_req_o = 0 immediately; state IDLE; all outputs 0.
